// File: rtl/qr_pkg.sv
// Shared state encoding, CORDIC mode constants and schedule-size helper for the
// Givens QR scheduler.
package qr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_NEXT,
        ST_FIN
    } state_t;

    localparam logic MODE_VEC = 1'b0;
    localparam logic MODE_ROT = 1'b1;

    // Engine operations in one full N x N decomposition.
    function automatic int total_ops(input int n);
        int acc;
        acc = 0;
        for (int j = 0; j < n - 1; j++) begin
            acc += (n - 1 - j) * (n - j);
        end
        return acc;
    endfunction

endpackage

// File: rtl/qr_index_gen.sv
// Loop counters for the Givens schedule: column-major annihilation j, row pair
// (i-1, i) walking upward, and the column currently being processed.
module qr_index_gen
    import qr_pkg::*;
#(
    parameter int N  = 4,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          advance,
    output logic [AW-1:0] row_a,
    output logic [AW-1:0] row_b,
    output logic [AW-1:0] col,
    output logic          mode,
    output logic          last
);

    localparam logic [AW-1:0] IDX_ONE  = AW'(1);
    localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);
    localparam logic [AW-1:0] IDX_PEN  = AW'(N - 2);

    logic [AW-1:0] j;
    logic          col_done;
    logic          pair_done;

    // row_a is kept as its own register so the upper row address never has to
    // be derived by subtraction from row_b.
    assign col_done  = (col == IDX_LAST);
    assign pair_done = (row_a == j);
    assign last      = col_done && pair_done && (j == IDX_PEN);
    assign mode      = (col == j) ? MODE_VEC : MODE_ROT;

    // NOTE: non-blocking assignments here so every counter sees the pre-edge
    // value of the others when the nested-loop carry ripples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j     <= '0;
            row_a <= '0;
            row_b <= '0;
            col   <= '0;
        end else if (load) begin
            j     <= '0;
            row_a <= IDX_PEN;
            row_b <= IDX_LAST;
            col   <= '0;
        end else if (advance) begin
            if (!col_done) begin
                col <= col + IDX_ONE;
            end else if (!pair_done) begin
                row_a <= row_a - IDX_ONE;
                row_b <= row_b - IDX_ONE;
                col   <= j;
            end else if (last) begin
                j     <= '0;
                row_a <= '0;
                row_b <= '0;
                col   <= '0;
            end else begin
                j     <= j + IDX_ONE;
                row_a <= IDX_PEN;
                row_b <= IDX_LAST;
                col   <= j + IDX_ONE;
            end
        end
    end

endmodule

// File: rtl/qr_givens_scheduler.sv
// Givens-rotation QR scheduler: sequences one shared iterative CORDIC engine
// through the vectoring/rotation schedule against an external matrix bank.
module qr_givens_scheduler
    import qr_pkg::*;
#(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter int ITER = 6,
    parameter int AW   = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   rd_row_a,
    output logic [AW-1:0]   rd_row_b,
    output logic [AW-1:0]   rd_col,
    input  logic [DW-1:0]   rd_data_a,
    input  logic [DW-1:0]   rd_data_b,
    output logic            wr_en,
    output logic [AW-1:0]   wr_row_a,
    output logic [AW-1:0]   wr_row_b,
    output logic [AW-1:0]   wr_col,
    output logic [DW-1:0]   wr_data_a,
    output logic [DW-1:0]   wr_data_b,
    output logic            cordic_go,
    output logic            cordic_mode,
    output logic [DW-1:0]   cordic_x,
    output logic [DW-1:0]   cordic_y,
    output logic [ITER-1:0] cordic_dir_in,
    input  logic            cordic_done,
    input  logic [DW-1:0]   cordic_xo,
    input  logic [DW-1:0]   cordic_yo,
    input  logic [ITER-1:0] cordic_dir_out
);

    state_t        state;
    logic          idx_load;
    logic          idx_advance;
    logic          idx_last;
    logic          idx_mode;
    logic [AW-1:0] idx_row_a;
    logic [AW-1:0] idx_row_b;
    logic [AW-1:0] idx_col;

    assign idx_load    = (state == ST_IDLE) && start;
    assign idx_advance = (state == ST_NEXT);

    qr_index_gen #(
        .N  (N),
        .AW (AW)
    ) u_index_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (idx_load),
        .advance (idx_advance),
        .row_a   (idx_row_a),
        .row_b   (idx_row_b),
        .col     (idx_col),
        .mode    (idx_mode),
        .last    (idx_last)
    );

    // Counters only move in NEXT, so addresses and mode are steady through
    // ISSUE, WAIT and WRITE of each op.
    assign rd_row_a    = idx_row_a;
    assign rd_row_b    = idx_row_b;
    assign rd_col      = idx_col;
    assign cordic_mode = idx_mode;

    // Operands are registered at the end of ISSUE, so cordic_go rises in the
    // same cycle the engine first sees valid, stable operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            wr_en         <= 1'b0;
            cordic_go     <= 1'b0;
            cordic_x      <= '0;
            cordic_y      <= '0;
            cordic_dir_in <= '0;
            wr_row_a      <= '0;
            wr_row_b      <= '0;
            wr_col        <= '0;
            wr_data_a     <= '0;
            wr_data_b     <= '0;
        end else begin
            cordic_go <= 1'b0;
            wr_en     <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cordic_x  <= rd_data_a;
                    cordic_y  <= rd_data_b;
                    cordic_go <= 1'b1;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cordic_done) begin
                        wr_en     <= 1'b1;
                        wr_row_a  <= idx_row_a;
                        wr_row_b  <= idx_row_b;
                        wr_col    <= idx_col;
                        wr_data_a <= cordic_xo;
                        // The vectoring op annihilates the lower element exactly.
                        wr_data_b <= (idx_mode == MODE_VEC) ? '0 : cordic_yo;
                        if (idx_mode == MODE_VEC) begin
                            cordic_dir_in <= cordic_dir_out;
                        end
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (idx_last) begin
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end else begin
                        state <= ST_ISSUE;
                    end
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qr_givens_scheduler.sv
// Scoreboard bench for qr_givens_scheduler: a matrix bank and mock CORDIC engine
// drive an N=4 instance checked against a loop-level schedule model, plus a fixed N=2 instance.
module tb_qr_givens_scheduler;
    import qr_pkg::*;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int ITER = 6;
    localparam int AW   = 2;

    typedef struct { int ra; int rb; int c; bit vec; int dir; } op_t;
    typedef struct { int ra; int rb; int c; int da; int db; } wr_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic clk, rst_n;

    // N = 4 instance
    logic            start, busy, done, wr_en, cordic_go, cordic_mode, cordic_done;
    logic [AW-1:0]   rd_row_a, rd_row_b, rd_col, wr_row_a, wr_row_b, wr_col;
    logic [DW-1:0]   rd_data_a, rd_data_b, wr_data_a, wr_data_b;
    logic [DW-1:0]   cordic_x, cordic_y, cordic_xo, cordic_yo;
    logic [ITER-1:0] cordic_dir_in, cordic_dir_out;

    // N = 2 instance
    logic            s_start, s_busy, s_done, s_wr_en, s_go, s_mode, s_cdone;
    logic [0:0]      s_rd_row_a, s_rd_row_b, s_rd_col, s_wr_row_a, s_wr_row_b, s_wr_col;
    logic [DW-1:0]   s_rd_data_a, s_rd_data_b, s_wr_data_a, s_wr_data_b;
    logic [DW-1:0]   s_x, s_y, s_xo, s_yo;
    logic [ITER-1:0] s_dir_in, s_dir_out;

    logic [DW-1:0]   bank  [N][N];
    logic [DW-1:0]   ref_m [N][N];
    logic [ITER-1:0] ref_dir;
    logic            bank_load;

    op_t sched_q[$];
    wr_t wr_q[$];
    op_t s_go_q[$];
    wr_t s_wr_q[$];

    int  go_cnt = 0, wr_cnt = 0, done_cnt = 0;
    int  s_go_cnt = 0, s_wr_cnt = 0, s_done_cnt = 0;
    int  op_idx = 0;
    int  spur_req = 0;
    bit  reset_run = 0;

    qr_givens_scheduler #(.N(N), .DW(DW), .ITER(ITER)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_row_a(rd_row_a), .rd_row_b(rd_row_b), .rd_col(rd_col),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr_en(wr_en), .wr_row_a(wr_row_a), .wr_row_b(wr_row_b), .wr_col(wr_col),
        .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
        .cordic_go(cordic_go), .cordic_mode(cordic_mode),
        .cordic_x(cordic_x), .cordic_y(cordic_y), .cordic_dir_in(cordic_dir_in),
        .cordic_done(cordic_done), .cordic_xo(cordic_xo), .cordic_yo(cordic_yo),
        .cordic_dir_out(cordic_dir_out)
    );

    qr_givens_scheduler #(.N(2), .DW(DW), .ITER(ITER)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
        .rd_row_a(s_rd_row_a), .rd_row_b(s_rd_row_b), .rd_col(s_rd_col),
        .rd_data_a(s_rd_data_a), .rd_data_b(s_rd_data_b),
        .wr_en(s_wr_en), .wr_row_a(s_wr_row_a), .wr_row_b(s_wr_row_b), .wr_col(s_wr_col),
        .wr_data_a(s_wr_data_a), .wr_data_b(s_wr_data_b),
        .cordic_go(s_go), .cordic_mode(s_mode),
        .cordic_x(s_x), .cordic_y(s_y), .cordic_dir_in(s_dir_in),
        .cordic_done(s_cdone), .cordic_xo(s_xo), .cordic_yo(s_yo),
        .cordic_dir_out(s_dir_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference schedule straight from the nested-loop definition.
    task automatic build_schedule(input int n);
        op_t e;
        for (int j = 0; j < n - 1; j++) begin
            for (int i = n - 1; i > j; i--) begin
                e.ra = i - 1; e.rb = i; e.c = j; e.vec = 1'b1; e.dir = 0;
                sched_q.push_back(e);
                for (int k = j + 1; k < n; k++) begin
                    e.c = k; e.vec = 1'b0;
                    sched_q.push_back(e);
                end
            end
        end
    endtask

    // Matrix bank seen by the N = 4 instance.
    assign rd_data_a = bank[rd_row_a][rd_col];
    assign rd_data_b = bank[rd_row_b][rd_col];
    always @(posedge clk) begin
        if (bank_load) begin
            bank <= ref_m;
        end else if (wr_en) begin
            bank[wr_row_a][wr_col] <= wr_data_a;
            bank[wr_row_b][wr_col] <= wr_data_b;
        end
    end

    // Mock engine for one op: check operands against the model, stall, answer.
    task automatic serve_op();
        op_t             e;
        wr_t             w;
        logic [DW-1:0]   x0, y0;
        logic            m0;
        logic [ITER-1:0] d0;
        int              lat;
        bit              stable;
        if (sched_q.size() == 0) begin
            check("go_unexpected", 1, 0);
            return;
        end
        e = sched_q.pop_front();
        op_idx++;
        check("op_row_a", int'(rd_row_a), e.ra);
        check("op_row_b", int'(rd_row_b), e.rb);
        check("op_col", int'(rd_col), e.c);
        check("op_mode", int'(cordic_mode), e.vec ? int'(MODE_VEC) : int'(MODE_ROT));
        check("op_x", int'(cordic_x), int'(ref_m[e.ra][e.c]));
        check("op_y", int'(cordic_y), int'(ref_m[e.rb][e.c]));
        check("op_dir_in", int'(cordic_dir_in), int'(ref_dir));
        x0 = cordic_x; y0 = cordic_y; m0 = cordic_mode; d0 = cordic_dir_in;
        lat = reset_run ? 4 : ((op_idx % 5 == 2) ? 6 : int'($urandom_range(1, 3)));
        stable = 1'b1;
        for (int k = 1; k < lat; k++) begin
            @(posedge clk); #1;
            if (!rst_n) return;
            if (cordic_x !== x0 || cordic_y !== y0 || cordic_mode !== m0 ||
                cordic_dir_in !== d0 || cordic_go !== 1'b0) stable = 1'b0;
        end
        check("op_hold_stable", int'(stable), 1);
        cordic_xo      = 8'($urandom);
        cordic_yo      = 8'($urandom);
        cordic_dir_out = 6'($urandom);
        cordic_done    = 1'b1;
        w.ra = e.ra; w.rb = e.rb; w.c = e.c;
        w.da = int'(cordic_xo);
        w.db = e.vec ? 0 : int'(cordic_yo);
        wr_q.push_back(w);
        ref_m[e.ra][e.c] = cordic_xo;
        ref_m[e.rb][e.c] = e.vec ? '0 : cordic_yo;
        if (e.vec) ref_dir = cordic_dir_out;
        if ($urandom_range(0, 2) == 0) begin
            // Spurious strobe while the scheduler is in WRITE.
            @(posedge clk); #1;
            cordic_xo      = ~cordic_xo;
            cordic_yo      = ~cordic_yo;
            cordic_dir_out = ~cordic_dir_out;
            cordic_done    = 1'b1;
        end
    endtask

    initial begin : engine
        int spur_served;
        spur_served    = 0;
        cordic_done    = 1'b0;
        cordic_xo      = '0;
        cordic_yo      = '0;
        cordic_dir_out = '0;
        forever begin
            @(posedge clk); #1;
            cordic_done = 1'b0;
            if (!rst_n) continue;
            if (spur_req != spur_served) begin
                cordic_done    = 1'b1;
                cordic_xo      = 8'($urandom);
                cordic_yo      = 8'($urandom);
                cordic_dir_out = 6'($urandom);
                spur_served    = spur_req;
            end else if (cordic_go) begin
                serve_op();
            end
        end
    end

    initial begin : monitor
        wr_t w;
        forever begin
            @(posedge clk); #1;
            if (cordic_go) go_cnt++;
            if (done) done_cnt++;
            if (wr_en) begin
                wr_cnt++;
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_row_a", int'(wr_row_a), w.ra);
                    check("wr_row_b", int'(wr_row_b), w.rb);
                    check("wr_col", int'(wr_col), w.c);
                    check("wr_data_a", int'(wr_data_a), w.da);
                    check("wr_data_b", int'(wr_data_b), w.db);
                end
            end
        end
    end

    // N = 2 fixed engine: answers in the cycle it sees cordic_go.
    assign s_rd_data_a = {7'h08, s_rd_col};
    assign s_rd_data_b = {7'h0c, s_rd_col};
    assign s_xo        = 8'd5;
    assign s_yo        = 8'd3;
    assign s_dir_out   = 6'b101010;
    initial begin
        s_cdone = 1'b0;
        forever begin
            @(posedge clk); #1;
            s_cdone = s_go && rst_n;
        end
    end

    initial begin : monitor2
        wr_t w;
        op_t e;
        forever begin
            @(posedge clk); #1;
            if (s_done) s_done_cnt++;
            if (s_go) begin
                s_go_cnt++;
                if (s_go_q.size() == 0) begin
                    check("n2_go_unexpected", 1, 0);
                end else begin
                    e = s_go_q.pop_front();
                    check("n2_mode", int'(s_mode), e.vec ? int'(MODE_VEC) : int'(MODE_ROT));
                    check("n2_col", int'(s_rd_col), e.c);
                    check("n2_x", int'(s_x), 16 + e.c);
                    check("n2_y", int'(s_y), 24 + e.c);
                    check("n2_dir_in", int'(s_dir_in), e.dir);
                end
            end
            if (s_wr_en) begin
                s_wr_cnt++;
                if (s_wr_q.size() == 0) begin
                    check("n2_wr_unexpected", 1, 0);
                end else begin
                    w = s_wr_q.pop_front();
                    check("n2_wr_rows", int'({s_wr_row_a, s_wr_row_b}), w.ra * 2 + w.rb);
                    check("n2_wr_col", int'(s_wr_col), w.c);
                    check("n2_wr_data_a", int'(s_wr_data_a), w.da);
                    check("n2_wr_data_b", int'(s_wr_data_b), w.db);
                end
            end
        end
    end

    initial begin : main
        int  base_go, base_wr, base_done;
        bit  repulsed;
        op_t e;
        wr_t w;
        rst_n = 1'b0; start = 1'b0; s_start = 1'b0; bank_load = 1'b0;
        ref_dir = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                ref_m[r][c] = 8'($urandom);
        repeat (3) @(posedge clk);
        #2;
        check("rst_outputs", int'(|{busy, done, wr_en, cordic_go, cordic_mode, rd_row_a,
              rd_row_b, rd_col, wr_row_a, wr_row_b, wr_col, wr_data_a, wr_data_b,
              cordic_x, cordic_y, cordic_dir_in}), 0);
        rst_n = 1'b1;
        bank_load = 1'b1;
        @(posedge clk); #2;
        bank_load = 1'b0;
        check("total_ops_n4", total_ops(4), 20);
        check("total_ops_n2", total_ops(2), 2);

        // Spurious engine strobe while idle.
        spur_req = 1;
        repeat (4) @(posedge clk);
        #2;
        check("idle_spur_busy", int'(busy), 0);
        check("idle_spur_wr", wr_cnt, 0);
        check("idle_spur_go", go_cnt, 0);
        check("idle_spur_dir", int'(cordic_dir_in), 0);
        check("idle_spur_data", int'(wr_data_a), 0);

        // N = 2 with a fixed engine.
        e.ra = 0; e.rb = 1; e.c = 0; e.vec = 1'b1; e.dir = 0;  s_go_q.push_back(e);
        e.c = 1; e.vec = 1'b0; e.dir = 42;                       s_go_q.push_back(e);
        w.ra = 0; w.rb = 1; w.c = 0; w.da = 5; w.db = 0;        s_wr_q.push_back(w);
        w.c = 1; w.db = 3;                                       s_wr_q.push_back(w);
        s_start = 1'b1;
        @(posedge clk); #2;
        s_start = 1'b0;
        check("n2_busy_after_start", int'(s_busy), 1);
        for (int c = 0; c < 200 && s_done_cnt == 0; c++) begin
            @(posedge clk); #2;
        end
        repeat (5) @(posedge clk);
        #2;
        check("n2_done_count", s_done_cnt, 1);
        check("n2_wr_count", s_wr_cnt, 2);
        check("n2_go_count", s_go_cnt, 2);
        check("n2_busy_after_done", int'(s_busy), 0);

        // N = 4 full run, start re-pulsed around op 7.
        build_schedule(N);
        base_go = go_cnt; base_wr = wr_cnt; base_done = done_cnt;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        repulsed = 1'b0;
        for (int c = 0; c < 5000 && done_cnt == base_done; c++) begin
            @(posedge clk); #2;
            if (start) begin
                start = 1'b0;
            end else if (!repulsed && go_cnt - base_go >= 7) begin
                start    = 1'b1;
                repulsed = 1'b1;
            end
        end
        start = 1'b0;
        check("run_done_seen", done_cnt - base_done, 1);
        @(posedge clk); #2;
        check("busy_after_done", int'(busy), 0);
        repeat (10) @(posedge clk);
        #2;
        check("run_go_count", go_cnt - base_go, 20);
        check("run_wr_count", wr_cnt - base_wr, 20);
        check("run_done_count", done_cnt - base_done, 1);
        check("run_sched_left", sched_q.size(), 0);
        check("run_wr_left", wr_q.size(), 0);

        // Reset asserted in the middle of WAIT.
        build_schedule(N);
        reset_run = 1'b1;
        base_go = go_cnt;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int c = 0; c < 2000 && go_cnt - base_go < 3; c++) begin
            @(posedge clk); #2;
        end
        check("rst_reached_op3", go_cnt - base_go, 3);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_outputs", int'(|{busy, done, wr_en, cordic_go, cordic_mode, rd_row_a,
              rd_row_b, rd_col, wr_row_a, wr_row_b, wr_col, wr_data_a, wr_data_b,
              cordic_x, cordic_y, cordic_dir_in}), 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        base_go = go_cnt; base_wr = wr_cnt; base_done = done_cnt;
        repeat (25) @(posedge clk);
        #2;
        check("post_rst_go", go_cnt - base_go, 0);
        check("post_rst_wr", wr_cnt - base_wr, 0);
        check("post_rst_done", done_cnt - base_done, 0);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_wr_left", wr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
